ps2_key_tracker: RTL

Receive-only PS/2 keyboard front end that feeds the memory-mapped input writer. Synchronises the raw PS/2 clock and data lines, deframes 11-bit device-to-host frames, and decodes make, break (F0) and extended (E0) prefixes. Tracks one configurable key and provides a level output and a press pulse. The memory writer samples the level every cycle.

---
 rtl/ps2_key_tracker_if.sv | 22 ++
 rtl/ps2_key_tracker.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker_if.sv
// PS/2 keyboard tracker bus: raw PS/2 lines in, decoded key events out.
interface ps2_key_tracker_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       frame_error;
    logic       key_pressed_pulse;
    logic       key_is_down;

    // Keyboard / host side: drives the PS/2 lines, observes key events
    modport master (
        output PS2_CLK, PS2_DAT,
        input  scancode, scancode_valid, frame_error, key_pressed_pulse, key_is_down
    );

    // Tracker side: samples the PS/2 lines, produces key events
    modport slave (
        input  PS2_CLK, PS2_DAT,
        output scancode, scancode_valid, frame_error, key_pressed_pulse, key_is_down
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// Receive-only PS/2 keyboard front end: synchronises the PS/2 lines,
// deframes 11-bit frames, decodes E0/F0 prefixes and tracks one key.
module ps2_key_tracker #(
    parameter logic [7:0]  KEY_CODE       = 8'h29,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              n_reset,
    ps2_key_tracker_if.slave  bus
);

    localparam int unsigned          TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic             clk_s1_q, clk_s2_q, clk_s3_q;
    logic             dat_s1_q, dat_s2_q;
    logic             fall;

    state_t           state_q;
    logic [9:0]       shift_q;
    logic [3:0]       bit_cnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic             break_pending_q;
    logic             ext_pending_q;

    logic [7:0]       scancode_q;
    logic             scancode_valid_q;
    logic             frame_error_q;
    logic             key_pressed_pulse_q;
    logic             key_is_down_q;

    logic             frame_ok;
    logic [7:0]       rx_byte;

    // Two-flop synchronisers, third clock flop for edge detection; idle bus is high
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= bus.PS2_CLK;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= bus.PS2_DAT;
            dat_s2_q <= dat_s1_q;
        end
    end

    // PS/2 data is valid at the clock's falling edge: previous sample high, current low
    assign fall     = clk_s3_q & ~clk_s2_q;

    // shift_q holds {stop, parity, data[7:0]} once the stop bit has been shifted in
    assign rx_byte  = shift_q[7:0];
    assign frame_ok = (^shift_q[8:0]) & shift_q[9];

    // Frame receiver, timeout and make/break decoder with registered outputs
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q             <= IDLE;
            shift_q             <= '0;
            bit_cnt_q           <= '0;
            tmo_q               <= '0;
            break_pending_q     <= 1'b0;
            ext_pending_q       <= 1'b0;
            scancode_q          <= '0;
            scancode_valid_q    <= 1'b0;
            frame_error_q       <= 1'b0;
            key_pressed_pulse_q <= 1'b0;
            key_is_down_q       <= 1'b0;
        end else begin
            scancode_valid_q    <= 1'b0;
            frame_error_q       <= 1'b0;
            key_pressed_pulse_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (fall) begin
                        if (!dat_s2_q) begin
                            state_q   <= RECV;
                            bit_cnt_q <= '0;
                            tmo_q     <= '0;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                    end
                end

                RECV: begin
                    if (fall) begin
                        shift_q   <= {dat_s2_q, shift_q[9:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        tmo_q     <= '0;
                        if (bit_cnt_q == 4'd9) begin
                            state_q <= CHECK;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        frame_error_q <= 1'b1;
                        state_q       <= IDLE;
                        shift_q       <= '0;
                        bit_cnt_q     <= '0;
                        tmo_q         <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                CHECK: begin
                    state_q <= IDLE;
                    if (frame_ok) begin
                        scancode_q       <= rx_byte;
                        scancode_valid_q <= 1'b1;
                        if (rx_byte == 8'hE0) begin
                            ext_pending_q <= 1'b1;
                        end else if (rx_byte == 8'hF0) begin
                            break_pending_q <= 1'b1;
                        end else begin
                            if (!ext_pending_q && rx_byte == KEY_CODE) begin
                                if (break_pending_q) begin
                                    key_is_down_q <= 1'b0;
                                end else if (!key_is_down_q) begin
                                    key_is_down_q       <= 1'b1;
                                    key_pressed_pulse_q <= 1'b1;
                                end
                            end
                            break_pending_q <= 1'b0;
                            ext_pending_q   <= 1'b0;
                        end
                    end else begin
                        frame_error_q <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.scancode          = scancode_q;
    assign bus.scancode_valid    = scancode_valid_q;
    assign bus.frame_error       = frame_error_q;
    assign bus.key_pressed_pulse = key_pressed_pulse_q;
    assign bus.key_is_down       = key_is_down_q;

endmodule
